// File: rtl/pci_target_responder.sv
`default_nettype none
// ============================================================================
//  Module      : pci_target_responder
//  Description : PCI memory target for the inbound Amiga window. Claims a
//                single-data-phase memory cycle with medium DEVSEL decode,
//                performs one local 32-bit transfer via REQ/GNT/ACK, then
//                completes, disconnects (burst) or retries (no grant).
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_target_responder #(
  parameter logic [2:0] TARGET_BASE = 3'b000,
  parameter int         RETRY_LIMIT = 16
) (
  input  logic        i_clk40,
  input  logic        i_resetn,
  input  logic        i_framen,
  input  logic        i_irdyn,
  input  logic [31:0] i_ad_in,
  input  logic [3:0]  i_cben,
  output logic        o_devseln,
  output logic        o_trdyn,
  output logic        o_stopn,
  output logic        o_target_oen,
  output logic [31:0] o_ad_out,
  output logic        o_ad_oen,
  output logic        o_par,
  output logic        o_par_oen,
  output logic        o_local_req,
  output logic        o_local_rw,
  output logic [29:0] o_local_a,
  output logic [3:0]  o_local_ben,
  output logic [31:0] o_local_dout,
  input  logic        i_local_gnt,
  input  logic        i_local_ack,
  input  logic [31:0] i_local_din
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_BUSY     = 3'd1,
    S_CLAIM    = 3'd2,
    S_WAIT     = 3'd3,
    S_XFER     = 3'd4,
    S_DATA     = 3'd5,
    S_STOPPING = 3'd6,
    S_TURN     = 3'd7
  } state_t;

  localparam logic [4:0] c_retry_lim = 5'(RETRY_LIMIT);
  localparam logic [4:0] c_cnt_max   = 5'h1F;

  state_t      r_state,       w_state_nxt;
  logic        r_frame_prev;
  logic [4:0]  r_cnt,         w_cnt_nxt;
  logic        r_acked,       w_acked_nxt;
  logic        r_ben_done,    w_ben_done_nxt;
  logic        r_devseln,     w_devseln_nxt;
  logic        r_trdyn,       w_trdyn_nxt;
  logic        r_stopn,       w_stopn_nxt;
  logic        r_target_oen,  w_target_oen_nxt;
  logic [31:0] r_ad_out,      w_ad_out_nxt;
  logic        r_ad_oen,      w_ad_oen_nxt;
  logic        r_par,         w_par_nxt;
  logic        r_par_oen,     w_par_oen_nxt;
  logic        r_local_req,   w_local_req_nxt;
  logic        r_local_rw,    w_local_rw_nxt;
  logic [29:0] r_local_a,     w_local_a_nxt;
  logic [3:0]  r_local_ben,   w_local_ben_nxt;
  logic [31:0] r_local_dout,  w_local_dout_nxt;

  logic w_addr_phase;
  logic w_cmd_ok;
  logic w_hit;

  // Address phase detection and window/command decode
  always_comb begin
    w_addr_phase = !i_framen && r_frame_prev;
    w_cmd_ok     = (i_cben == 4'b0110) || (i_cben == 4'b1100) ||
                   (i_cben == 4'b1110) || (i_cben == 4'b0111) ||
                   (i_cben == 4'b1111);
    w_hit        = (i_ad_in[31:29] == TARGET_BASE) &&
                   (i_ad_in[1:0] == 2'b00) && w_cmd_ok;
  end

  // State register and all registered outputs; reset returns everything idle
  always_ff @(posedge i_clk40) begin
    if (!i_resetn) begin
      r_state      <= S_IDLE;
      r_frame_prev <= 1'b1;
      r_cnt        <= 5'd0;
      r_acked      <= 1'b0;
      r_ben_done   <= 1'b0;
      r_devseln    <= 1'b1;
      r_trdyn      <= 1'b1;
      r_stopn      <= 1'b1;
      r_target_oen <= 1'b1;
      r_ad_out     <= 32'h0;
      r_ad_oen     <= 1'b1;
      r_par        <= 1'b0;
      r_par_oen    <= 1'b1;
      r_local_req  <= 1'b0;
      r_local_rw   <= 1'b1;
      r_local_a    <= 30'h0;
      r_local_ben  <= 4'hF;
      r_local_dout <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_prev <= i_framen;
      r_cnt        <= w_cnt_nxt;
      r_acked      <= w_acked_nxt;
      r_ben_done   <= w_ben_done_nxt;
      r_devseln    <= w_devseln_nxt;
      r_trdyn      <= w_trdyn_nxt;
      r_stopn      <= w_stopn_nxt;
      r_target_oen <= w_target_oen_nxt;
      r_ad_out     <= w_ad_out_nxt;
      r_ad_oen     <= w_ad_oen_nxt;
      r_par        <= w_par_nxt;
      r_par_oen    <= w_par_oen_nxt;
      r_local_req  <= w_local_req_nxt;
      r_local_rw   <= w_local_rw_nxt;
      r_local_a    <= w_local_a_nxt;
      r_local_ben  <= w_local_ben_nxt;
      r_local_dout <= w_local_dout_nxt;
    end
  end

  // Next-state and next-output decode; everything holds unless changed
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_acked_nxt      = r_acked;
    w_ben_done_nxt   = r_ben_done;
    w_devseln_nxt    = r_devseln;
    w_trdyn_nxt      = r_trdyn;
    w_stopn_nxt      = r_stopn;
    w_target_oen_nxt = r_target_oen;
    w_ad_out_nxt     = r_ad_out;
    w_ad_oen_nxt     = r_ad_oen;
    w_par_nxt        = r_par;
    w_par_oen_nxt    = 1'b1;          // parity driven for one clock only
    w_local_req_nxt  = r_local_req;
    w_local_rw_nxt   = r_local_rw;
    w_local_a_nxt    = r_local_a;
    w_local_ben_nxt  = r_local_ben;
    w_local_dout_nxt = r_local_dout;

    case (r_state)
      S_IDLE: begin
        if (w_addr_phase) begin
          w_local_a_nxt  = i_ad_in[31:2];
          w_local_rw_nxt = ~i_cben[0];      // all accepted reads have CBE[0]=0
          w_state_nxt    = w_hit ? S_CLAIM : S_BUSY;
        end
      end

      S_BUSY: begin
        if (i_framen && i_irdyn) begin
          w_state_nxt = S_IDLE;
        end
      end

      S_CLAIM: begin
        w_target_oen_nxt = 1'b0;
        w_devseln_nxt    = 1'b0;
        if (r_local_rw) begin
          w_ad_oen_nxt    = 1'b0;
          w_local_req_nxt = 1'b1;         // reads request on entry to WAIT
        end
        w_cnt_nxt      = 5'd0;
        w_acked_nxt    = 1'b0;
        w_ben_done_nxt = 1'b0;
        w_state_nxt    = S_WAIT;
      end

      S_WAIT: begin
        // First data-phase IRDY captures byte enables; writes also need data
        if (!i_irdyn && !r_ben_done) begin
          w_ben_done_nxt  = 1'b1;
          w_local_ben_nxt = i_cben;
          if (!r_local_rw) begin
            w_local_req_nxt  = 1'b1;
            w_local_dout_nxt = i_ad_in;
          end
        end
        // Grant takes priority over an expiring counter
        if (i_local_gnt && r_local_req) begin
          w_state_nxt = S_XFER;
        end else if (r_cnt == c_retry_lim) begin
          w_local_req_nxt = 1'b0;
          w_stopn_nxt     = 1'b0;
          w_trdyn_nxt     = 1'b1;
          w_state_nxt     = S_STOPPING;
        end else if (r_cnt != c_cnt_max) begin
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end

      S_XFER: begin
        if (!r_acked) begin
          if (i_local_ack) begin
            w_local_req_nxt = 1'b0;
            w_acked_nxt     = 1'b1;
            if (r_local_rw) begin
              w_ad_out_nxt = i_local_din;
            end
          end
        end else begin
          // Data is ready; a master still holding FRAME gets disconnect-with-data
          w_trdyn_nxt = 1'b0;
          if (!i_framen) begin
            w_stopn_nxt = 1'b0;
          end
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (!i_irdyn) begin
          w_trdyn_nxt   = 1'b1;
          w_devseln_nxt = 1'b1;
          w_stopn_nxt   = i_framen;
          if (r_local_rw) begin
            w_par_nxt     = ^{r_ad_out, i_cben};
            w_par_oen_nxt = 1'b0;
          end
          w_state_nxt = S_STOPPING;
        end
      end

      S_STOPPING: begin
        if (i_framen) begin
          w_devseln_nxt = 1'b1;
          w_trdyn_nxt   = 1'b1;
          w_stopn_nxt   = 1'b1;
          w_state_nxt   = S_TURN;
        end
      end

      S_TURN: begin
        w_target_oen_nxt = 1'b1;
        w_ad_oen_nxt     = 1'b1;
        w_state_nxt      = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_devseln    = r_devseln;
  assign o_trdyn      = r_trdyn;
  assign o_stopn      = r_stopn;
  assign o_target_oen = r_target_oen;
  assign o_ad_out     = r_ad_out;
  assign o_ad_oen     = r_ad_oen;
  assign o_par        = r_par;
  assign o_par_oen    = r_par_oen;
  assign o_local_req  = r_local_req;
  assign o_local_rw   = r_local_rw;
  assign o_local_a    = r_local_a;
  assign o_local_ben  = r_local_ben;
  assign o_local_dout = r_local_dout;

endmodule
`default_nettype wire

// File: tb/tb_pci_target_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_target_responder
//  Description : Directed bench for the PCI target responder with a local
//                transfer / read-data scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_target_responder;

  logic        clk = 1'b0;
  logic        resetn, framen, irdyn, gnt, ack;
  logic [31:0] ad_in, din;
  logic [3:0]  cben;
  logic        devseln, trdyn, stopn, target_oen, ad_oen, par, par_oen;
  logic        local_req, local_rw;
  logic [31:0] ad_out, local_dout;
  logic [29:0] local_a;
  logic [3:0]  local_ben;

  typedef struct {
    logic        rw;
    logic [29:0] a;
    logic [3:0]  ben;
    logic [31:0] dout;
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] rd_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_rise = 0;
  logic req_d = 1'b0;

  pci_target_responder #(.TARGET_BASE(3'b000), .RETRY_LIMIT(16)) dut (
    .i_clk40     (clk),
    .i_resetn    (resetn),
    .i_framen    (framen),
    .i_irdyn     (irdyn),
    .i_ad_in     (ad_in),
    .i_cben      (cben),
    .o_devseln   (devseln),
    .o_trdyn     (trdyn),
    .o_stopn     (stopn),
    .o_target_oen(target_oen),
    .o_ad_out    (ad_out),
    .o_ad_oen    (ad_oen),
    .o_par       (par),
    .o_par_oen   (par_oen),
    .o_local_req (local_req),
    .o_local_rw  (local_rw),
    .o_local_a   (local_a),
    .o_local_ben (local_ben),
    .o_local_dout(local_dout),
    .i_local_gnt (gnt),
    .i_local_ack (ack),
    .i_local_din (din)
  );

  always #5 clk = ~clk;

  // Count local requests launched
  always @(negedge clk) begin
    if (local_req && !req_d) n_rise <= n_rise + 1;
    req_d <= local_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the expected local transfer and compare against what the DUT presents
  task automatic sb_local(input string tag);
    xfer_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_req"}, {31'd0, local_req}, 32'd1);
      chk({tag, "_rw_a"}, {1'b0, local_rw, local_a}, {1'b0, e.rw, e.a});
      chk({tag, "_ben"}, {28'd0, local_ben}, {28'd0, e.ben});
      if (!e.rw) chk({tag, "_dout"}, local_dout, e.dout);
    end
  endtask

  task automatic sb_rd(input string tag);
    logic [31:0] e;
    if (rd_q.size() == 0) begin
      chk({tag, "_rd_empty"}, 32'd1, 32'd0);
    end else begin
      e = rd_q.pop_front();
      chk({tag, "_ad_out"}, ad_out, e);
    end
  endtask

  // Single-phase read with minimum local latency (GNT at N+2, ACK at N+3)
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [3:0] ben, input logic [31:0] data);
    logic expar;
    expar = ^{data, ben};
    framen = 1'b0; ad_in = addr; cben = 4'b0110;
    exp_q.push_back('{1'b1, addr[31:2], ben, 32'h0});
    tick();                                            // edge N
    framen = 1'b1; irdyn = 1'b0; cben = ben; ad_in = 32'h0;
    tick();                                            // N+1
    chk({tag, "_claim"}, {28'd0, devseln, target_oen, ad_oen, local_req}, 32'b0001);
    gnt = 1'b1;
    tick();                                            // N+2
    sb_local(tag);
    gnt = 1'b0; ack = 1'b1; din = data; rd_q.push_back(data);
    tick();                                            // N+3
    chk({tag, "_ackdrop"}, {30'd0, local_req, trdyn}, 32'b01);
    ack = 1'b0; din = 32'h0;
    tick();                                            // N+4
    chk({tag, "_trdy"}, {30'd0, trdyn, stopn}, 32'b01);
    sb_rd(tag);
    tick();                                            // N+5
    chk({tag, "_done"}, {28'd0, trdyn, devseln, stopn, par_oen}, 32'b1110);
    chk({tag, "_par"}, {31'd0, par}, {31'd0, expar});
    irdyn = 1'b1;
    tick();                                            // N+6
    chk({tag, "_hold"}, {30'd0, par_oen, target_oen}, 32'b10);
    tick();                                            // N+7
    chk({tag, "_release"}, {30'd0, target_oen, ad_oen}, 32'b11);
  endtask

  int rises0;

  initial begin
    resetn = 1'b0; framen = 1'b1; irdyn = 1'b1; gnt = 1'b0; ack = 1'b0;
    ad_in = 32'h0; cben = 4'hF; din = 32'h0;
    tick(); tick();
    chk("reset_ctl", {24'd0, devseln, trdyn, stopn, target_oen, ad_oen, par_oen, local_req, local_rw},
        32'b11111101);
    chk("reset_data", ad_out | local_dout | {31'd0, par}, 32'h0);
    chk("reset_local", {local_ben, local_a[27:0]}, {4'hF, 28'h0});
    resetn = 1'b1;
    tick();

    // Single read of 0x0000_1000
    do_read("rd1", 32'h0000_1000, 4'b1110, 32'hDEADBEEF);

    // Single write of 0x0100_0008
    framen = 1'b0; ad_in = 32'h0100_0008; cben = 4'b0111;
    exp_q.push_back('{1'b0, 30'h0040_0002, 4'b1100, 32'h12345678});
    tick();                                            // N
    framen = 1'b1; irdyn = 1'b0; ad_in = 32'h12345678; cben = 4'b1100;
    tick();                                            // N+1
    chk("wr_claim", {27'd0, devseln, target_oen, ad_oen, local_req, local_rw}, 32'b00100);
    chk("wr_addr", {2'b0, local_a}, 32'h0040_0002);
    tick();                                            // N+2
    chk("wr_req", {31'd0, local_req}, 32'd1);
    gnt = 1'b1;
    tick();                                            // N+3
    sb_local("wr");
    gnt = 1'b0; ack = 1'b1;
    tick();                                            // N+4
    chk("wr_ackdrop", {31'd0, local_req}, 32'd0);
    ack = 1'b0;
    tick();                                            // N+5
    chk("wr_trdy", {30'd0, trdyn, ad_oen}, 32'b01);
    tick();                                            // N+6
    chk("wr_done", {29'd0, trdyn, devseln, par_oen}, 32'b111);
    irdyn = 1'b1;
    tick(); tick();
    chk("wr_release", {30'd0, target_oen, ad_oen}, 32'b11);

    // Misses: outside the window, and an I/O read command
    for (int m = 0; m < 2; m++) begin
      framen = 1'b0;
      ad_in  = (m == 0) ? 32'h2000_0000 : 32'h0000_1000;
      cben   = (m == 0) ? 4'b0110 : 4'b0010;
      tick();
      framen = 1'b1; irdyn = 1'b0; cben = 4'b0000; ad_in = 32'h0;
      for (int k = 0; k < 5; k++) begin
        if (k == 3) irdyn = 1'b1;
        tick();
        chk($sformatf("miss%0d_t%0d", m, k), {29'd0, devseln, target_oen, local_req}, 32'b110);
      end
    end

    // Retry: no grant, master holds FRAME until STOP is seen
    framen = 1'b0; ad_in = 32'h0000_2000; cben = 4'b0110;
    tick();                                            // N
    irdyn = 1'b0; cben = 4'b0000; ad_in = 32'h0;
    tick();                                            // N+1
    chk("rty_claim", {30'd0, devseln, local_req}, 32'b01);
    for (int i = 0; i < 16; i++) tick();               // N+17
    chk("rty_wait", {30'd0, stopn, local_req}, 32'b11);
    tick();                                            // N+18
    chk("rty_stop", {28'd0, stopn, trdyn, local_req, devseln}, 32'b0100);
    tick(); tick();                                    // N+20
    chk("rty_hold", {31'd0, stopn}, 32'd0);
    framen = 1'b1;
    tick();                                            // N+21
    chk("rty_high", {28'd0, stopn, devseln, trdyn, target_oen}, 32'b1110);
    irdyn = 1'b1;
    tick();                                            // N+22
    chk("rty_turn", {30'd0, target_oen, ad_oen}, 32'b11);

    // Burst read: disconnect with data, one local transfer
    rises0 = n_rise;
    framen = 1'b0; ad_in = 32'h0000_3000; cben = 4'b0110;
    exp_q.push_back('{1'b1, 30'h0000_0C00, 4'b0000, 32'h0});
    tick();                                            // N
    irdyn = 1'b0; cben = 4'b0000; ad_in = 32'h0;
    tick();                                            // N+1
    chk("bst_claim", {30'd0, devseln, local_req}, 32'b01);
    gnt = 1'b1;
    tick();                                            // N+2
    sb_local("bst");
    gnt = 1'b0; ack = 1'b1; din = 32'hCAFEF00D; rd_q.push_back(32'hCAFEF00D);
    tick();                                            // N+3
    ack = 1'b0; din = 32'h0;
    tick();                                            // N+4
    chk("bst_trdy_stop", {30'd0, trdyn, stopn}, 32'b00);
    sb_rd("bst");
    tick();                                            // N+5
    chk("bst_done", {29'd0, trdyn, devseln, stopn}, 32'b110);
    chk("bst_par", {31'd0, par}, {31'd0, ^{32'hCAFEF00D, 4'b0000}});
    framen = 1'b1;
    tick();                                            // N+6
    chk("bst_high", {28'd0, devseln, trdyn, stopn, target_oen}, 32'b1110);
    irdyn = 1'b1;
    tick();                                            // N+7
    chk("bst_turn", {31'd0, target_oen}, 32'd1);
    chk("bst_one_xfer", n_rise - rises0, 32'd1);

    // Reset while a local request is outstanding in XFER
    framen = 1'b0; ad_in = 32'h0000_4000; cben = 4'b0110;
    tick();
    framen = 1'b1; irdyn = 1'b0; cben = 4'b0000; ad_in = 32'h0;
    tick();
    gnt = 1'b1;
    tick();
    chk("rst_inxfer", {31'd0, local_req}, 32'd1);
    gnt = 1'b0; resetn = 1'b0;
    tick();
    chk("rst_ctl", {24'd0, devseln, trdyn, stopn, target_oen, ad_oen, par_oen, local_req, local_rw},
        32'b11111101);
    chk("rst_local", {local_ben, local_a[27:0]}, {4'hF, 28'h0});
    resetn = 1'b1; irdyn = 1'b1;
    tick();
    do_read("rd2", 32'h0000_5000, 4'b0011, 32'h5A5A_0F0F);

    chk("sb_drained", exp_q.size() + rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
